// File: rtl/qs_isrt.sv
// Streaming insertion sorter: collects one sop/eop packet of up to N keys in
// sorted order, then replays it on a ready/valid output stream.
module qs_isrt #(
    parameter int unsigned W       = 32,
    parameter int unsigned N       = 16,
    parameter bit          DESCEND = 1'b0,
    parameter bit          SIGNED  = 1'b0,
    parameter int unsigned KEY_W   = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic         in_sop,
    input  logic         in_eop,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy_r,
    output logic         out_vld_r,
    output logic         out_sop_r,
    output logic         out_eop_r,
    output logic         out_err_r,
    output logic [W-1:0] out_dat_r,
    input  logic         out_rdy
);

    localparam int unsigned NW = $clog2(N + 1);
    localparam int unsigned KW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a     [N];
    logic [W-1:0]   a_nx  [N];
    logic [W-1:0]   a_ins [N];
    logic [NW-1:0]  n, n_nx;
    logic [KW-1:0]  k, k_nx;
    logic           err, err_nx;
    logic [N-1:0]   le;
    logic           in_acc, out_acc;
    logic           rdy_nx, vld_nx, sop_nx, eop_nx, oerr_nx;
    logic [W-1:0]   dat_nx;

    // True when x sorts at or before y; the key is the top KEY_W bits of the word.
    function automatic logic orders_le(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [KEY_W-1:0] kx;
        logic [KEY_W-1:0] ky;
        kx = x[W-1 -: KEY_W];
        ky = y[W-1 -: KEY_W];
        if (SIGNED) begin
            kx[KEY_W-1] = ~kx[KEY_W-1];
            ky[KEY_W-1] = ~ky[KEY_W-1];
        end
        return DESCEND ? (kx >= ky) : (kx <= ky);
    endfunction

    // le is a prefix mask over the sorted array, so slot i takes a[i], the new key or a[i-1].
    always_comb begin
        for (int i = 0; i < N; i++) begin
            le[i] = (NW'(i) < n) && orders_le(a[i], in_dat);
        end
        for (int i = 0; i < N; i++) begin
            if (i == 0) begin
                a_ins[i] = le[0] ? a[0] : in_dat;
            end else begin
                a_ins[i] = le[i] ? a[i] : (le[i-1] ? in_dat : a[i-1]);
            end
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a;
        n_nx     = n;
        k_nx     = k;
        err_nx   = err;
        in_acc   = in_vld & in_rdy_r;
        out_acc  = out_vld_r & out_rdy;

        case (state)
            IDLE: begin
                if (in_acc && in_sop) begin
                    a_nx[0]  = in_dat;
                    n_nx     = NW'(1);
                    k_nx     = '0;
                    err_nx   = 1'b0;
                    state_nx = in_eop ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (in_acc) begin
                    if (n < NW'(N)) begin
                        a_nx = a_ins;
                        n_nx = n + NW'(1);
                    end else begin
                        err_nx = 1'b1;
                    end
                    if (in_sop) begin
                        err_nx = 1'b1;
                    end
                    if (in_eop) begin
                        k_nx     = '0;
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_acc) begin
                    if (out_eop_r) begin
                        n_nx     = '0;
                        k_nx     = '0;
                        state_nx = IDLE;
                    end else begin
                        k_nx = k + KW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Outputs are registered from next-state values so they lead the state by nothing.
        rdy_nx  = (state_nx != DRAIN);
        vld_nx  = (state_nx == DRAIN);
        dat_nx  = vld_nx ? a_nx[k_nx] : '0;
        sop_nx  = vld_nx && (k_nx == '0);
        eop_nx  = vld_nx && (NW'(k_nx) == (n_nx - NW'(1)));
        oerr_nx = eop_nx & err_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            a         <= '{default: '0};
            n         <= '0;
            k         <= '0;
            err       <= 1'b0;
            in_rdy_r  <= 1'b1;
            out_vld_r <= 1'b0;
            out_sop_r <= 1'b0;
            out_eop_r <= 1'b0;
            out_err_r <= 1'b0;
            out_dat_r <= '0;
        end else begin
            state     <= state_nx;
            a         <= a_nx;
            n         <= n_nx;
            k         <= k_nx;
            err       <= err_nx;
            in_rdy_r  <= rdy_nx;
            out_vld_r <= vld_nx;
            out_sop_r <= sop_nx;
            out_eop_r <= eop_nx;
            out_err_r <= oerr_nx;
            out_dat_r <= dat_nx;
        end
    end

endmodule
